// File: rtl/sdrc_init_pkg.sv
// Shared types and constants for the SDRAM power-up initialisation sequencer.
// Command words are ordered {cs_n, ras_n, cas_n, we_n}.
package sdrc_init_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_WAIT = 4'd1,
    ST_PRE  = 4'd2,
    ST_TRP  = 4'd3,
    ST_REF  = 4'd4,
    ST_TRFC = 4'd5,
    ST_LMR  = 4'd6,
    ST_TMRD = 4'd7,
    ST_DONE = 4'd8
  } init_state_e;

  localparam logic [3:0] CMD_NOP = 4'b1111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;

  localparam int A10_IDX = 10;

  // Only the three single-cycle command states put anything other than NOP on the pins.
  function automatic logic [3:0] cmd_for(input init_state_e st);
    logic [3:0] c;
    case (st)
      ST_PRE:  c = CMD_PRE;
      ST_REF:  c = CMD_REF;
      ST_LMR:  c = CMD_LMR;
      default: c = CMD_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sdrc_init_timer.sv
// Loadable down-counter used to time the NOP gaps of the init sequence.
// Holds at zero once expired; a load always wins over the decrement.
module sdrc_init_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_r;

  // Count register: load, decrement, or hold at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {CNT_W{1'b0}}) begin
      cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/sdrc_init_seq.sv
// SDRAM power-up sequencer: CKE wait, PRECHARGE ALL, N x AUTO REFRESH, LOAD MODE REGISTER.
// All pin outputs are registered from the next-state decode, so they line up with the state.
module sdrc_init_seq
  import sdrc_init_pkg::*;
#(
  parameter int WAIT_CYCLES = 505,
  parameter int T_RP        = 2,
  parameter int REF_COUNT   = 2,
  parameter int T_RFC       = 7,
  parameter int T_MRD       = 2,
  parameter int CNT_W       = 16
) (
  input  logic        sdram_clk,
  input  logic        sdram_resetn,
  input  logic        cfg_sdr_en,
  input  logic [12:0] cfg_sdr_mode_reg,
  output logic        sdr_cke,
  output logic        sdr_cs_n,
  output logic        sdr_ras_n,
  output logic        sdr_cas_n,
  output logic        sdr_we_n,
  output logic [12:0] sdr_addr,
  output logic [1:0]  sdr_ba,
  output logic        sdr_init_done,
  output logic        init_busy
);

  localparam int RC_W = $clog2(REF_COUNT + 1);
  localparam logic [RC_W-1:0]  REF_MAX = RC_W'(REF_COUNT);
  localparam logic [CNT_W-1:0] LD_WAIT = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_TRP  = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] LD_TRFC = CNT_W'(T_RFC - 1);
  localparam logic [CNT_W-1:0] LD_TMRD = CNT_W'(T_MRD - 1);

  init_state_e      state_r, state_nxt;
  logic [RC_W-1:0]  ref_cnt_r;
  logic             tmr_load, tmr_zero;
  logic [CNT_W-1:0] tmr_val;

  logic [3:0]  cmd_nxt, cmd_r;
  logic [12:0] addr_nxt, addr_r;
  logic [1:0]  ba_nxt, ba_r;
  logic        cke_nxt, cke_r;
  logic        done_nxt, done_r;
  logic        busy_nxt, busy_r;

  sdrc_init_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (sdram_clk),
    .rst_n    (sdram_resetn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // State register.
  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Refresh counter: counts REF commands issued, never cleared except by reset.
  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      ref_cnt_r <= {RC_W{1'b0}};
    end else if (state_r == ST_REF) begin
      ref_cnt_r <= ref_cnt_r + RC_W'(1);
    end else begin
      ref_cnt_r <= ref_cnt_r;
    end
  end

  // Next-state decode; the timer is loaded on the edge that enters each wait state.
  always_comb begin
    state_nxt = state_r;
    tmr_load  = 1'b0;
    tmr_val   = {CNT_W{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (cfg_sdr_en) begin
          state_nxt = ST_WAIT;
          tmr_load  = 1'b1;
          tmr_val   = LD_WAIT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (tmr_zero) state_nxt = ST_PRE;
        else          state_nxt = ST_WAIT;
      end
      ST_PRE: begin
        state_nxt = ST_TRP;
        tmr_load  = 1'b1;
        tmr_val   = LD_TRP;
      end
      ST_TRP: begin
        if (tmr_zero) state_nxt = ST_REF;
        else          state_nxt = ST_TRP;
      end
      ST_REF: begin
        state_nxt = ST_TRFC;
        tmr_load  = 1'b1;
        tmr_val   = LD_TRFC;
      end
      ST_TRFC: begin
        if (!tmr_zero)             state_nxt = ST_TRFC;
        else if (ref_cnt_r < REF_MAX) state_nxt = ST_REF;
        else                       state_nxt = ST_LMR;
      end
      ST_LMR: begin
        state_nxt = ST_TMRD;
        tmr_load  = 1'b1;
        tmr_val   = LD_TMRD;
      end
      ST_TMRD: begin
        if (tmr_zero) state_nxt = ST_DONE;
        else          state_nxt = ST_TMRD;
      end
      ST_DONE: state_nxt = ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Pin values for the upcoming cycle, decoded from the state being entered.
  always_comb begin
    cmd_nxt  = cmd_for(state_nxt);
    addr_nxt = 13'h0000;
    ba_nxt   = 2'b00;
    cke_nxt  = (state_nxt != ST_IDLE);
    done_nxt = (state_nxt == ST_DONE);
    busy_nxt = (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
    case (state_nxt)
      ST_PRE:  addr_nxt[A10_IDX] = 1'b1;
      ST_LMR:  addr_nxt = cfg_sdr_mode_reg;
      default: addr_nxt = 13'h0000;
    endcase
  end

  // Output registers.
  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      cmd_r  <= CMD_NOP;
      addr_r <= 13'h0000;
      ba_r   <= 2'b00;
      cke_r  <= 1'b0;
      done_r <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      cmd_r  <= cmd_nxt;
      addr_r <= addr_nxt;
      ba_r   <= ba_nxt;
      cke_r  <= cke_nxt;
      done_r <= done_nxt;
      busy_r <= busy_nxt;
    end
  end

  assign {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = cmd_r;
  assign sdr_addr      = addr_r;
  assign sdr_ba        = ba_r;
  assign sdr_cke       = cke_r;
  assign sdr_init_done = done_r;
  assign init_busy     = busy_r;

endmodule
